// File: rtl/full_adder_reg_pkg.sv
// Shared full-adder cell equations for the registered adder and its ripple cells.
package full_adder_reg_pkg;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Majority of the three inputs.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_reg_cell.sv
// Purely combinational 1-bit full adder cell: one ripple stage of full_adder_reg.
module full_adder_cell
  import full_adder_reg_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = fa_sum(a, b, ci);
  assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/full_adder_reg.sv
// Registered WIDTH-bit ripple-carry adder: {Cout,S} = A + B + Cin, one-cycle latency.
module full_adder_reg
  import full_adder_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = Cin;

  // Ripple chain: carry[i] feeds cell i, carry[WIDTH] is the overflow.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  // Result only loads on a valid operand; otherwise the last result is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum_c;
        Cout <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed and random checks of full_adder_reg at WIDTH=1 and WIDTH=8.
module tb_full_adder_reg;

  logic       clk;
  logic       rst;
  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;
  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [7:0] s8;
  logic       co8, ov8;

  int errors;
  int checks;

  full_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .S(s1), .Cout(co1), .out_valid(ov1)
  );

  full_adder_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
    .S(s8), .Cout(co8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    // Reset values while rst held from time zero
    #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_initial_w1: got %b want 000", {s1, co1, ov1});
    end
    checks++;
    if ({s8, co8, ov8} !== 10'h000) begin
      errors++;
      $display("FAIL reset_initial_w8: got %h want 000", {s8, co8, ov8});
    end
    @(negedge clk);
    rst = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b111) begin
      errors++;
      $display("FAIL reset_preload: got %b want 111", {s1, co1, ov1});
    end
    // Async assertion mid-cycle must clear outputs before the next edge
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: got %b want 000", {s1, co1, ov1});
    end
    @(negedge clk);
    rst = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic test_exhaustive_w1();
    logic [2:0] vec;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      case (vec)
        3'b000: exp = 2'b00;
        3'b001: exp = 2'b10;
        3'b010: exp = 2'b10;
        3'b011: exp = 2'b01;
        3'b100: exp = 2'b10;
        3'b101: exp = 2'b01;
        3'b110: exp = 2'b01;
        default: exp = 2'b11;
      endcase
      @(negedge clk);
      v1 = 1'b1; a1 = vec[2]; b1 = vec[1]; c1 = vec[0];
      @(posedge clk); #1;
      checks++;
      if ({s1, co1} !== exp) begin
        errors++;
        $display("FAIL truth_%b: got S,Cout=%b want %b", vec, {s1, co1}, exp);
      end
      checks++;
      if (ov1 !== 1'b1) begin
        errors++;
        $display("FAIL truth_valid_%b: got %b want 1", vec, ov1);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b110) begin
      errors++;
      $display("FAIL hold: got S,Cout,valid=%b want 110", {s1, co1, ov1});
    end
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b110) begin
      errors++;
      $display("FAIL hold_second: got %b want 110", {s1, co1, ov1});
    end
  endtask

  task automatic test_wrap_w8();
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({co8, s8, ov8} !== {1'b1, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL wrap_ff_01: got Cout=%b S=%h valid=%b want 1 00 1", co8, s8, ov8);
    end
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({co8, s8, ov8} !== {1'b1, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL wrap_ff_ff_1: got Cout=%b S=%h valid=%b want 1 ff 1", co8, s8, ov8);
    end
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({co8, s8} !== {1'b0, 8'h47}) begin
      errors++;
      $display("FAIL add_12_34_1: got Cout=%b S=%h want 0 47", co8, s8);
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_inflight: got %b want 000", {s1, co1, ov1});
    end
    @(negedge clk);
    rst = 1'b0;
    v1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_stale: got %b want 000", {s1, co1, ov1});
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int         bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      v8 = 1'b1;
      a8 = 8'($urandom_range(255, 0));
      b8 = 8'($urandom_range(255, 0));
      c8 = 1'($urandom_range(1, 0));
      exp = 9'(a8) + 9'(b8) + 9'(c8);
      @(posedge clk); #1;
      checks++;
      if ({co8, s8, ov8} !== {exp, 1'b1}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_%0d: got Cout,S=%h valid=%b want %h 1", i, {co8, s8}, ov8, exp);
        bad++;
      end
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    test_reset();
    test_exhaustive_w1();
    test_hold();
    test_wrap_w8();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
